// File: rtl/frame_buffer_loader.sv
// Packs a 9-bit RGB pixel stream into 54-bit words and writes one frame into
// the HUB75 frame RAM that is not being displayed, once per bank-swap toggle.
module frame_buffer_loader #(
  parameter int WORDS_PER_FRAME = 3360,
  parameter int ADDR_W          = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_require_data,
  input  logic              i_disp_sel,
  input  logic              i_pix_valid,
  input  logic              i_pix_sof,
  input  logic [8:0]        i_pix_data,
  output logic              o_pix_ready,
  output logic              o_frame_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [53:0]       o_wr_data,
  output logic              o_wr1,
  output logic              o_wr2,
  output logic              o_busy,
  output logic              o_overrun
);

  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

  state_t            state, state_next;
  logic              req_q;
  logic              tgt;        // 1 = load RAM1, 0 = load RAM2
  logic              overrun;
  logic [2:0]        slot;
  logic [ADDR_W-1:0] word_cnt;
  logic [53:0]       pack_word;
  logic              swap;
  logic              start;
  logic              xfer;
  logic              last_word;

  assign swap      = i_require_data ^ req_q;
  assign last_word = (word_cnt == ADDR_W'(WORDS_PER_FRAME - 1));
  assign xfer      = o_pix_ready & i_pix_valid;

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    o_pix_ready = 1'b0;
    o_frame_req = 1'b0;
    o_wr1       = 1'b0;
    o_wr2       = 1'b0;
    unique case (state)
      IDLE: begin
        if (swap) begin
          state_next = REQ;
          start      = 1'b1;
        end
      end
      REQ: begin
        o_frame_req = 1'b1;
        state_next  = FILL;
      end
      FILL: begin
        o_pix_ready = 1'b1;
        if (i_pix_valid && !i_pix_sof && slot == 3'd5) state_next = WRITE;
      end
      WRITE: begin
        o_wr1      = tgt;
        o_wr2      = ~tgt;
        state_next = last_word ? IDLE : FILL;
      end
      default: state_next = IDLE;
    endcase
    // A swap mid-load aborts and restarts; a WRITE strobe this cycle still lands.
    if (swap && state != IDLE) begin
      state_next = REQ;
      start      = 1'b1;
    end
  end

  // NOTE: the packing register is reset too, because the write-data output
  // must read 0 while reset is asserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q     <= 1'b0;
      tgt       <= 1'b0;
      overrun   <= 1'b0;
      slot      <= 3'd0;
      word_cnt  <= '0;
      pack_word <= '0;
    end else begin
      req_q <= i_require_data;
      if (swap && state != IDLE) overrun <= 1'b1;

      if (start) begin
        tgt      <= ~i_disp_sel;
        slot     <= 3'd0;
        word_cnt <= '0;
      end else if (xfer) begin
        if (i_pix_sof) begin
          pack_word[17:9] <= i_pix_data;
          slot            <= 3'd1;
          word_cnt        <= '0;
        end else begin
          // Pixel pairs are swapped within each 18-bit half-lane of the word.
          unique case (slot)
            3'd0:    pack_word[17:9]  <= i_pix_data;
            3'd1:    pack_word[8:0]   <= i_pix_data;
            3'd2:    pack_word[35:27] <= i_pix_data;
            3'd3:    pack_word[26:18] <= i_pix_data;
            3'd4:    pack_word[53:45] <= i_pix_data;
            default: pack_word[44:36] <= i_pix_data;
          endcase
          slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
        end
      end else if (state == WRITE) begin
        slot     <= 3'd0;
        word_cnt <= last_word ? '0 : word_cnt + ADDR_W'(1);
      end
    end
  end

  assign o_wr_addr = word_cnt;
  assign o_wr_data = pack_word;
  assign o_busy    = (state != IDLE);
  assign o_overrun = overrun;

endmodule

// File: tb/tb_frame_buffer_loader.sv
// Directed bench for frame_buffer_loader: reset, full frame, packing,
// backpressure, sof resync, overrun restart and reset mid-load.
module tb_frame_buffer_loader;

  localparam int WORDS  = 3360;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_require_data = 1'b0;
  logic              i_disp_sel = 1'b0;
  logic              i_pix_valid = 1'b0;
  logic              i_pix_sof = 1'b0;
  logic [8:0]        i_pix_data = '0;
  logic              o_pix_ready;
  logic              o_frame_req;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [53:0]       o_wr_data;
  logic              o_wr1;
  logic              o_wr2;
  logic              o_busy;
  logic              o_overrun;

  frame_buffer_loader #(.WORDS_PER_FRAME(WORDS), .ADDR_W(ADDR_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_require_data (i_require_data),
    .i_disp_sel     (i_disp_sel),
    .i_pix_valid    (i_pix_valid),
    .i_pix_sof      (i_pix_sof),
    .i_pix_data     (i_pix_data),
    .o_pix_ready    (o_pix_ready),
    .o_frame_req    (o_frame_req),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_wr1          (o_wr1),
    .o_wr2          (o_wr2),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [53:0]       data;
    logic              bank1;
  } wr_t;

  wr_t wq[$];
  int  both_cnt = 0;
  int  req_cnt  = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  // First word of a stream whose pixels are 1..6: s4,s5,s2,s3,s0,s1 from MSB.
  localparam logic [53:0] WORD_1_6  = {9'h005, 9'h006, 9'h003, 9'h004, 9'h001, 9'h002};
  localparam logic [53:0] WORD_7_12 = {9'h00B, 9'h00C, 9'h009, 9'h00A, 9'h007, 9'h008};
  localparam logic [53:0] WORD_SOF  = {9'd68, 9'd69, 9'd66, 9'd67, 9'd64, 9'd65};

  always @(negedge clk) begin
    if (o_wr1 || o_wr2) wq.push_back('{addr: o_wr_addr, data: o_wr_data, bank1: o_wr1});
    if (o_wr1 && o_wr2) both_cnt++;
    if (o_frame_req) req_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [53:0] pack6(input int first);
    logic [8:0] p[6];
    for (int k = 0; k < 6; k++) p[k] = 9'(first + k);
    return {p[4], p[5], p[2], p[3], p[0], p[1]};
  endfunction

  // Toggle the swap request and confirm the one-cycle frame request.
  task automatic start_load(input logic disp);
    @(negedge clk);
    i_disp_sel     = disp;
    i_require_data = ~i_require_data;
    @(negedge clk);
    check("frame_req", o_frame_req, 1);
    check("busy_req", o_busy, 1);
  endtask

  // Hold valid high and stream n pixels (value base+i+1); sof on index sof_idx.
  task automatic stream(input int n, input int sof_idx, input int base,
                        output int cycles, output int lows);
    int i = 0;
    cycles = 0;
    lows   = 0;
    while (i < n && cycles < 8 * n + 16) begin
      @(negedge clk);
      i_pix_valid = 1'b1;
      i_pix_data  = 9'(base + i + 1);
      i_pix_sof   = (i == sof_idx);
      cycles++;
      if (o_pix_ready) i++;
      else lows++;
    end
    check("stream_done", i, n);
    @(negedge clk);
    i_pix_valid = 1'b0;
    i_pix_sof   = 1'b0;
  endtask

  initial begin
    int cyc, lows, bad_addr, bad_data, n1;

    // Reset state
    #12;
    check("rst_ctl", {o_pix_ready, o_frame_req, o_wr1, o_wr2, o_busy, o_overrun}, 0);
    check("rst_addr", o_wr_addr, 0);
    check("rst_data", o_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", o_busy, 0);

    // Full frame into RAM2, packing and backpressure
    start_load(1'b1);
    stream(6 * WORDS, -1, 0, cyc, lows);
    check("last_wr2", o_wr2, 1);
    check("last_busy", o_busy, 1);
    check("last_addr", o_wr_addr, WORDS - 1);
    @(negedge clk);
    check("busy_fall", o_busy, 0);
    #1;
    check("bp_cycles", cyc, 7 * WORDS - 1);
    check("bp_lows", lows, WORDS - 1);
    check("frame_wr_cnt", wq.size(), WORDS);
    bad_addr = 0; bad_data = 0; n1 = 0;
    foreach (wq[j]) begin
      if (wq[j].addr != ADDR_W'(j)) bad_addr++;
      if (wq[j].data != pack6(6 * j + 1)) bad_data++;
      if (wq[j].bank1) n1++;
    end
    check("frame_addr_seq", bad_addr, 0);
    check("frame_data", bad_data, 0);
    check("frame_no_wr1", n1, 0);
    check("pack_word0", wq[0].data, WORD_1_6);
    check("req_once", req_cnt, 1);
    wq.delete();

    // Resync on the 4th pixel of word 10, into RAM1
    start_load(1'b0);
    stream(69, 63, 0, cyc, lows);
    stream(6 * 99, -1, 100, cyc, lows);
    #1;
    check("sof_wr_cnt", wq.size(), 110);
    check("sof_addr", wq[10].addr, 0);
    check("sof_data", wq[10].data, WORD_SOF);
    check("sof_last_addr", wq[109].addr, 99);
    bad_addr = 0; n1 = 0;
    foreach (wq[j]) begin
      if (wq[j].addr != ADDR_W'(j < 10 ? j : j - 10)) bad_addr++;
      if (wq[j].bank1) n1++;
    end
    check("sof_addr_seq", bad_addr, 0);
    check("sof_all_wr1", n1, 110);
    check("no_overrun_yet", o_overrun, 0);

    // Overrun: toggle at word 100, restart on RAM2
    @(negedge clk);
    start_load(1'b1);
    check("overrun_set", o_overrun, 1);
    #1;
    wq.delete();
    stream(12, -1, 0, cyc, lows);
    #1;
    check("ovr_wr_cnt", wq.size(), 2);
    check("ovr_addr0", wq[0].addr, 0);
    check("ovr_bank", wq[0].bank1, 0);
    check("ovr_data0", wq[0].data, WORD_1_6);
    check("ovr_addr1", wq[1].addr, 1);
    check("ovr_data1", wq[1].data, WORD_7_12);
    check("overrun_sticky", o_overrun, 1);

    // Reset mid-FILL, then restart from address 0
    @(negedge clk);
    i_pix_valid = 1'b1;
    check("pre_rst_ready", o_pix_ready, 1);
    #2;
    rst_n          = 1'b0;
    i_require_data = 1'b0;
    #1;
    check("mid_rst_ctl", {o_pix_ready, o_frame_req, o_wr1, o_wr2, o_busy, o_overrun}, 0);
    check("mid_rst_addr", o_wr_addr, 0);
    check("mid_rst_data", o_wr_data, 0);
    i_pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", o_busy, 0);
    #1;
    wq.delete();
    start_load(1'b0);
    stream(6, -1, 0, cyc, lows);
    #1;
    check("rst_wr_cnt", wq.size(), 1);
    check("rst_wr_addr", wq[0].addr, 0);
    check("rst_wr_bank", wq[0].bank1, 1);
    check("rst_wr_data", wq[0].data, WORD_1_6);
    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
